// File: rtl/load_extend_unit_if.sv
// Bundles the pipeline-side load request/result signals and the data-memory read port.
interface load_extend_unit_if;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [4:0]  ld_rd;
    logic        flush;
    logic        ld_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd_out;
    logic        ld_misalign;
    logic        ld_timeout;

    modport slave (
        input  ld_req, ld_addr, ld_funct3, ld_rd, flush, mem_gnt, mem_rvalid, mem_rdata,
        output ld_busy, mem_req, mem_addr, ld_valid, ld_data, ld_rd_out, ld_misalign,
        output ld_timeout
    );

    modport master (
        output ld_req, ld_addr, ld_funct3, ld_rd, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  ld_busy, mem_req, mem_addr, ld_valid, ld_data, ld_rd_out, ld_misalign,
        input  ld_timeout
    );
endinterface

// File: rtl/load_extend_unit.sv
// MEM-stage load unit: issues a word-aligned read over req/gnt/rvalid and returns the
// byte/halfword/word result sign- or zero-extended according to funct3.
module load_extend_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    load_extend_unit_if.slave        bus
);

    localparam int unsigned CntW = 10;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [1:0]      r_addr_lo;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [31:0]     r_mem_addr;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_ld_data;
    logic [4:0]      r_ld_rd_out;
    logic            r_misalign;
    logic            r_timeout;

    logic            w_accept;
    logic            w_take;
    logic            w_fault;
    logic            w_cnt_hit;
    logic            w_timeout_evt;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ext;

    assign w_accept  = (r_state == StIdle) || (r_state == StDone);
    assign w_take    = w_accept && bus.ld_req && !bus.flush;
    assign w_cnt_hit = (r_cnt == CntW'(TIMEOUT - 1));
    assign w_timeout_evt = (r_state == StWait) && !bus.flush && !bus.mem_rvalid && w_cnt_hit;

    always_comb begin
        w_fault = 1'b0;
        case (bus.ld_funct3)
            3'b001, 3'b101: w_fault = bus.ld_addr[0];
            3'b010:         w_fault = (bus.ld_addr[1:0] != 2'b00);
            3'b000, 3'b100: w_fault = 1'b0;
            default:        w_fault = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush always wins over a new request or a completing response
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: begin
                if (w_take && !w_fault) begin
                    w_state_next = StReq;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StReq: begin
                if (bus.mem_gnt) begin
                    if (bus.flush) begin
                        w_state_next = bus.mem_rvalid ? StIdle : StDrain;
                    end else begin
                        w_state_next = bus.mem_rvalid ? StDone : StWait;
                    end
                end else if (bus.flush) begin
                    w_state_next = StIdle;
                end
            end
            StWait: begin
                if (bus.flush) begin
                    w_state_next = bus.mem_rvalid ? StIdle : StDrain;
                end else if (bus.mem_rvalid) begin
                    w_state_next = StDone;
                end else if (w_cnt_hit) begin
                    w_state_next = StIdle;
                end
            end
            StDrain: begin
                if (bus.mem_rvalid || w_cnt_hit) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ld_busy  = (r_state == StReq) || (r_state == StWait) || (r_state == StDrain);
        bus.mem_req  = (r_state == StReq);
        bus.ld_valid = (r_state == StDone) && !bus.flush;
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.ld_data     = r_ld_data;
    assign bus.ld_rd_out   = r_ld_rd_out;
    assign bus.ld_misalign = r_misalign;
    assign bus.ld_timeout  = r_timeout;

    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0: w_byte = bus.mem_rdata[7:0];
            2'd1: w_byte = bus.mem_rdata[15:8];
            2'd2: w_byte = bus.mem_rdata[23:16];
            2'd3: w_byte = bus.mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_mem_addr  <= 32'h0;
            r_cnt       <= '0;
            r_ld_data   <= 32'h0;
            r_ld_rd_out <= 5'd0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_misalign <= w_take && w_fault;
            r_timeout  <= w_timeout_evt;
            if (w_take) begin
                r_addr_lo <= bus.ld_addr[1:0];
                r_funct3  <= bus.ld_funct3;
                r_rd      <= bus.ld_rd;
                if (!w_fault) begin
                    r_mem_addr <= {bus.ld_addr[31:2], 2'b00};
                end
            end
            // Counter restarts on any state change so each WAIT/DRAIN entry begins at 0
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == StWait) || (r_state == StDrain)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_state_next == StDone) begin
                r_ld_data   <= w_ext;
                r_ld_rd_out <= r_rd;
            end else if (w_timeout_evt) begin
                r_ld_data <= 32'h0;
            end
        end
    end

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Load-side counterpart of the store byte-enable path in the MEM stage of the pipelined RV32I core.
- Accepts a load from the pipeline and issues a word-aligned read to data memory with a req/gnt/rvalid handshake.
- Extracts the addressed byte/halfword/word and sign- or zero-extends it per funct3.
- Holds the pipeline while the access is in flight; supports flush, misalignment detection and a response timeout.

Parameters:
- TIMEOUT, 255: max cycles in WAIT/DRAIN without mem_rvalid before abort; range 1..1023.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- ld_req  input  1  load request; sampled only when ld_busy=0
- ld_addr  input  32  byte address
- ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_rd  input  5  destination register tag
- flush  input  1  abort current load (pipeline redirect)
- ld_busy  output  1  stall request to pipeline
- mem_req  output  1  memory read request
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data word
- ld_valid  output  1  one-cycle result strobe
- ld_data  output  32  extended load result
- ld_rd_out  output  5  tag of result
- ld_misalign  output  1  one-cycle fault strobe (misaligned or illegal funct3)
- ld_timeout  output  1  one-cycle timeout strobe

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- On reset: state=IDLE; mem_req, ld_valid, ld_misalign, ld_timeout = 0; ld_data, ld_rd_out, mem_addr = 0; counter = 0.
- ld_busy is combinational: 1 in REQ, WAIT and DRAIN; 0 in IDLE and DONE.
- States:
  - IDLE/DONE: on ld_req, latch addr[1:0], funct3 and rd into internal registers.
    - Fault check: illegal funct3 (011, 110, 111); LH/LHU with addr[0]=1; LW with addr[1:0]!=0.
    - Fault: pulse ld_misalign next cycle, stay IDLE, no memory access.
    - Else: go to REQ.
    - DONE always exits after one cycle (to IDLE, or REQ if a new load is taken).
  - REQ: mem_req=1, mem_addr held stable.
    - mem_gnt & mem_rvalid -> DONE.
    - mem_gnt only -> WAIT.
    - No gnt -> stay (no timeout in REQ).
  - WAIT: counter increments each cycle.
    - mem_rvalid -> DONE.
    - Counter reaches TIMEOUT -> pulse ld_timeout, ld_data=0, go to IDLE.
  - DRAIN: entered on flush in WAIT.
    - Discards the next mem_rvalid (no ld_valid), then goes to IDLE.
    - Timeout also returns to IDLE, with no ld_timeout pulse.
  - DONE: ld_valid=1 for exactly this cycle; ld_data and ld_rd_out valid.
- flush handling:
  - flush in REQ with no gnt -> IDLE, mem_req drops next cycle.
  - flush in REQ with gnt -> DRAIN, or IDLE if rvalid is also present.
  - flush in DONE suppresses ld_valid.
  - flush has priority over ld_req in the same cycle.
- Extraction uses latched addr[1:0]:
  - LB/LBU: byte = rdata[8*a+7:8*a]; LB sign-extends from bit 7, LBU zero-extends.
  - LH/LHU: half = a[1] ? rdata[31:16] : rdata[15:0]; LH sign-extends from bit 15, LHU zero-extends.
  - LW: rdata passed through.
- rdata is registered on the rvalid cycle.
- mem_rvalid in IDLE/DONE (not expected) is ignored.
- Latency: ld_req at edge N -> REQ in N+1 -> earliest ld_valid at N+2 (gnt & rvalid in the same cycle).
- Back-to-back: a new ld_req taken in DONE gives REQ the following cycle, with no idle bubble.
- Counter resets to 0 on every entry to WAIT or DRAIN.

Test Plan:
- LB/LBU: addr=0x1003, rdata=0x80FF7F01, gnt & rvalid in REQ -> LB ld_data=0xFFFFFF80 and LBU ld_data=0x00000080; ld_valid at N+2; mem_addr=0x1000.
- LH/LHU/LW: addr=0x2002, rdata=0x8001_1234 -> LH=0xFFFF8001, LHU=0x00008001; addr=0x2000 LW -> ld_data=0x80011234.
- Misalign: LW addr=0x3001, or funct3=011 -> ld_misalign pulses 1 cycle, mem_req never asserted, ld_busy stays 0.
- Wait states: gnt after 3 cycles, rvalid 5 cycles later -> ld_busy high throughout, single ld_valid, ld_rd_out = latched rd (e.g. 5'd17).
- Timeout: TIMEOUT=8, gnt but no rvalid -> ld_timeout after exactly 8 WAIT cycles, then IDLE; a late rvalid produces no ld_valid.
- Flush in WAIT then rvalid 2 cycles later -> no ld_valid, IDLE afterwards; next LBU addr=0x4000 completes normally. Reset asserted in WAIT -> all outputs 0 next cycle.
